elastic_config_loader: RTL and testbench

ELASTIC_CONFIG_LOADER -- requirements
Module: elastic_config_loader

---
 rtl/elastic_config_loader.sv | 169 ++++++++++++++++
 tb/tb_elastic_config_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_config_loader.sv
// ---------------------------------------------------------------------------
// elastic_config_loader
//
// Purpose:
//   Accepts a session of configuration beats from an upstream source
//   (valid/stop handshake) and rebroadcasts each legal beat on a registered
//   config bus, one cycle later, together with a one-hot write strobe that
//   selects the target ElasticPE. After the final beat the loader spends one
//   FLUSH cycle, during which the last strobe goes out. It then spends one
//   START cycle that pulses start_exec to every PE.
//
// Ports:
//   clk, reset_n             clock (rising edge) and async active-low reset
//   load_req                 one-cycle pulse that opens a session (IDLE only)
//   in_valid / in_stop       beat handshake; a beat is taken when
//                            in_valid && !in_stop
//   in_pe_id, in_context_index, in_input_idx_1/2, in_output_mask,
//   in_op, in_const, in_last beat payload
//   config_*                 registered broadcast config bus
//   write_config_data        one-hot per-PE write strobe (one cycle)
//   start_exec               one-cycle broadcast start pulse
//   mapping_context_max_id   highest legal context index seen this session
//   busy                     high in LOAD, FLUSH and START
//   error                    sticky flag: an illegal beat was seen this session
// ---------------------------------------------------------------------------
module elastic_config_loader #(
    parameter int unsigned PE_NUM                  = 16,
    parameter int unsigned PE_ID_WIDTH             = 4,
    parameter int unsigned CONTEXT_SIZE            = 8,
    parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
    parameter int unsigned NEIGHBOR_PE_NUM         = 4,
    parameter int unsigned OPERATION_BIT_LENGTH    = 4,
    parameter int unsigned DATA_WIDTH              = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,

    input  logic                               load_req,

    input  logic                               in_valid,
    output logic                               in_stop,
    input  logic [PE_ID_WIDTH-1:0]             in_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] in_context_index,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_idx_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_idx_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]         in_output_mask,
    input  logic [OPERATION_BIT_LENGTH-1:0]    in_op,
    input  logic [DATA_WIDTH-1:0]              in_const,
    input  logic                               in_last,

    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [PE_NUM-1:0]                  write_config_data,

    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               error
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StStart
    } state_e;

    state_e state_q;

    logic              pe_legal;
    logic              ctx_legal;
    logic              beat_legal;
    logic [PE_NUM-1:0] beat_onehot;

    // Beat legality and target decode. Comparisons are done at 32 bits so
    // that ids wider than the PE / context population are caught.
    always_comb begin
        pe_legal   = (32'(in_pe_id) < PE_NUM);
        ctx_legal  = (32'(in_context_index) < CONTEXT_SIZE);
        beat_legal = pe_legal && ctx_legal;
        beat_onehot = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            beat_onehot[i] = (32'(in_pe_id) == i);
        end
    end

    // Both handshake outputs are straight decodes of the state flop, so they
    // change only on a clock edge or on reset and carry no input path.
    always_comb begin
        in_stop = (state_q != StLoad);
        busy    = (state_q != StIdle);
    end

    // Single-process FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                 <= StIdle;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_output_PE_index  <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            config_index            <= '0;
            write_config_data       <= '0;
            start_exec              <= 1'b0;
            mapping_context_max_id  <= '0;
            error                   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a beat is taken below.
            write_config_data <= '0;
            start_exec        <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (load_req) begin
                        state_q                <= StLoad;
                        mapping_context_max_id <= '0;
                        error                  <= 1'b0;
                    end
                end

                StLoad: begin
                    // in_stop is low here, so any valid beat is consumed,
                    // legal or not. load_req is ignored in this state.
                    if (in_valid) begin
                        if (beat_legal) begin
                            config_input_PE_index_1 <= in_input_idx_1;
                            config_input_PE_index_2 <= in_input_idx_2;
                            config_output_PE_index  <= in_output_mask;
                            config_op               <= in_op;
                            config_const_data       <= in_const;
                            config_index            <= in_context_index;
                            write_config_data       <= beat_onehot;
                            if (in_context_index > mapping_context_max_id) begin
                                mapping_context_max_id <= in_context_index;
                            end
                        end else begin
                            error <= 1'b1;
                        end
                        if (in_last) begin
                            state_q <= StFlush;
                        end
                    end
                end

                StFlush: begin
                    // The final beat's strobe is visible during this cycle;
                    // start_exec goes out in the cycle after it.
                    state_q    <= StStart;
                    start_exec <= 1'b1;
                end

                StStart: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_config_loader.sv
// Scoreboard bench for elastic_config_loader. The driver pushes expected
// strobes / start pulses into queues as it issues beats; a monitor on the
// falling edge pops and compares whenever the DUT presents a strobe or start.
module tb_elastic_config_loader;

    localparam int PE_NUM = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_req = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_stop;
    logic [4:0]  in_pe_id = '0;
    logic [2:0]  in_context_index = '0;
    logic [2:0]  in_input_idx_1 = '0;
    logic [2:0]  in_input_idx_2 = '0;
    logic [3:0]  in_output_mask = '0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_const = '0;
    logic        in_last = 1'b0;

    logic [2:0]  config_input_PE_index_1;
    logic [2:0]  config_input_PE_index_2;
    logic [3:0]  config_output_PE_index;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic [2:0]  config_index;
    logic [15:0] write_config_data;
    logic        start_exec;
    logic [2:0]  mapping_context_max_id;
    logic        busy;
    logic        error;

    // PE_ID_WIDTH widened to 5 so that out-of-range PE ids can be driven.
    elastic_config_loader #(
        .PE_NUM                 (PE_NUM),
        .PE_ID_WIDTH            (5),
        .CONTEXT_SIZE           (8),
        .CONTEXT_SIZE_BIT_LENGTH(3),
        .INPUT_NUM_BIT_LENGTH   (3),
        .NEIGHBOR_PE_NUM        (4),
        .OPERATION_BIT_LENGTH   (4),
        .DATA_WIDTH             (32)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .load_req               (load_req),
        .in_valid               (in_valid),
        .in_stop                (in_stop),
        .in_pe_id               (in_pe_id),
        .in_context_index       (in_context_index),
        .in_input_idx_1         (in_input_idx_1),
        .in_input_idx_2         (in_input_idx_2),
        .in_output_mask         (in_output_mask),
        .in_op                  (in_op),
        .in_const               (in_const),
        .in_last                (in_last),
        .config_input_PE_index_1(config_input_PE_index_1),
        .config_input_PE_index_2(config_input_PE_index_2),
        .config_output_PE_index (config_output_PE_index),
        .config_op              (config_op),
        .config_const_data      (config_const_data),
        .config_index           (config_index),
        .write_config_data      (write_config_data),
        .start_exec             (start_exec),
        .mapping_context_max_id (mapping_context_max_id),
        .busy                   (busy),
        .error                  (error)
    );

    always #5 clk = ~clk;

    // Rising-edge count; a beat taken at edge N shows its strobe while cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] wcd;
        logic [16:0] fields;   // {idx1, idx2, mask, op, ctx}
        logic [31:0] cst;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [2:0] max_id;
        logic       err;
    } start_t;

    beat_t  exp_q[$];
    start_t start_q[$];
    beat_t  mon_b;
    start_t mon_s;

    int errors = 0;
    int checks = 0;

    // Reference model of the session, kept at the level of "what was sent".
    bit         m_load = 1'b0;
    logic [2:0] m_max = '0;
    bit         m_err = 1'b0;
    int         m_start_at = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares DUT strobes and start pulses against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (write_config_data !== '0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", 64'(write_config_data), 64'(0));
                end else begin
                    mon_b = exp_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(mon_b.cyc));
                    check("strobe_pe", 64'(write_config_data), 64'(mon_b.wcd));
                    check("config_fields",
                          64'({config_input_PE_index_1, config_input_PE_index_2,
                               config_output_PE_index, config_op, config_index}),
                          64'(mon_b.fields));
                    check("config_const", 64'(config_const_data), 64'(mon_b.cst));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_b = exp_q.pop_front();
                check("missing_strobe", 64'(write_config_data), 64'(mon_b.wcd));
            end

            if (start_exec === 1'b1) begin
                if (start_q.size() == 0) begin
                    check("spurious_start", 64'(start_exec), 64'(0));
                end else begin
                    mon_s = start_q.pop_front();
                    check("start_cycle", 64'(cyc), 64'(mon_s.cyc));
                    check("start_max_id", 64'(mapping_context_max_id), 64'(mon_s.max_id));
                    check("start_error", 64'(error), 64'(mon_s.err));
                    check("start_busy", 64'(busy), 64'(1));
                end
            end else if (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
                mon_s = start_q.pop_front();
                check("missing_start", 64'(start_exec), 64'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load();
        load_req = 1'b1;
        if (!m_load) begin
            m_load = 1'b1;
            m_max  = '0;
            m_err  = 1'b0;
        end
        tick();
        load_req = 1'b0;
    endtask

    // Drive one beat for the next rising edge and record what should follow.
    task automatic beat(input int pe, input int ctx, input bit last, input bit lreq);
        beat_t b;
        start_t s;
        in_pe_id         = 5'(pe);
        in_context_index = 3'(ctx);
        in_input_idx_1   = 3'($urandom);
        in_input_idx_2   = 3'($urandom);
        in_output_mask   = 4'($urandom);
        in_op            = 4'($urandom);
        in_const         = $urandom;
        in_last          = last;
        in_valid         = 1'b1;
        load_req         = lreq;
        check("in_stop", 64'(in_stop), 64'(!m_load));
        if (m_load) begin
            if (pe < PE_NUM) begin
                b.cyc    = cyc + 1;
                b.wcd    = 16'b1 << pe;
                b.fields = {in_input_idx_1, in_input_idx_2, in_output_mask, in_op,
                            in_context_index};
                b.cst    = in_const;
                exp_q.push_back(b);
                if (3'(ctx) > m_max) m_max = 3'(ctx);
            end else begin
                m_err = 1'b1;
            end
            if (last) begin
                m_load     = 1'b0;
                s.cyc      = cyc + 2;
                s.max_id   = m_max;
                s.err      = m_err;
                m_start_at = cyc + 2;
                start_q.push_back(s);
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        load_req = 1'b0;
    endtask

    // Wait until the session is back in IDLE and check the held results.
    task automatic end_session();
        while (cyc < m_start_at + 1) tick();
        check("busy_idle", 64'(busy), 64'(0));
        check("in_stop_idle", 64'(in_stop), 64'(1));
        check("max_id_hold", 64'(mapping_context_max_id), 64'(m_max));
        check("error_hold", 64'(error), 64'(m_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_stop"}, 64'(in_stop), 64'(1));
        check({tag, "_wcd"}, 64'(write_config_data), 64'(0));
        check({tag, "_start"}, 64'(start_exec), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_max_id"}, 64'(mapping_context_max_id), 64'(0));
        check({tag, "_bus"},
              64'({config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index,
                   config_op, config_index}), 64'(0));
        check({tag, "_const"}, 64'(config_const_data), 64'(0));
    endtask

    initial begin
        int n;
        #2;
        check_reset_outputs("reset");
        tick();
        reset_n = 1'b1;
        gap(2);

        // Basic three-beat session.
        do_load();
        beat(0, 0, 1'b0, 1'b0);
        beat(5, 2, 1'b0, 1'b0);
        beat(5, 1, 1'b1, 1'b0);
        end_session();
        gap(2);

        // Valid toggling every cycle.
        do_load();
        beat(1, 3, 1'b0, 1'b0);
        gap(1);
        beat(2, 4, 1'b0, 1'b0);
        gap(1);
        beat(15, 1, 1'b0, 1'b0);
        gap(1);
        beat(7, 0, 1'b1, 1'b0);
        end_session();

        // Out-of-range PE id; error must hold into IDLE.
        do_load();
        beat(3, 5, 1'b0, 1'b0);
        beat(16, 6, 1'b0, 1'b0);
        beat(4, 2, 1'b1, 1'b0);
        end_session();
        gap(3);
        check("error_sticky", 64'(error), 64'(1));

        // load_req during LOAD is ignored.
        do_load();
        beat(9, 4, 1'b0, 1'b0);
        beat(10, 1, 1'b0, 1'b1);
        beat(11, 2, 1'b1, 1'b0);
        end_session();

        // Valid while IDLE must not be consumed.
        beat(6, 6, 1'b1, 1'b0);
        gap(3);

        // Single-beat session at the top context slot.
        do_load();
        beat(12, 7, 1'b1, 1'b0);
        end_session();

        // Reset in the middle of a session.
        do_load();
        beat(3, 1, 1'b0, 1'b0);
        beat(7, 2, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_load = 1'b0;
        m_max  = '0;
        m_err  = 1'b0;
        exp_q.delete();
        start_q.delete();
        gap(2);
        reset_n = 1'b1;
        gap(5);

        // Randomised sessions.
        repeat (30) begin
            do_load();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                gap(int'($urandom_range(0, 2)));
                beat(int'($urandom_range(0, 19)), int'($urandom_range(0, 7)), i == n - 1,
                     $urandom_range(0, 7) == 0);
            end
            end_session();
            gap(int'($urandom_range(0, 2)));
        end

        gap(5);
        check("queues_drained", 64'(exp_q.size() + start_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
